mem_bhw_ram: RTL and testbench

Parametrised byte-addressable data RAM supporting byte, halfword and word accesses with big-endian lane mapping. Loads can be sign- or zero-extended, and misaligned accesses are detected. Requests use a valid/ready handshake, and responses arrive in order after a configurable fixed latency. It replaces the fixed-size halfword-only data memory on the CPU data path and sits between the load/store unit and the memory-mapped bus.

---
 rtl/mem_bhw_ram_if.sv | 38 +++
 rtl/mem_bhw_ram.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_bhw_ram.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bhw_ram_if.sv
// ----------------------------------------------------------------------------
// mem_bhw_ram_if
// Request/response bundle between a load/store unit (master) and mem_bhw_ram
// (slave).
//   req_valid/req_ready : request handshake, transfer when both high at clk edge
//   req_we              : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr            : byte address, ADDR_W bits
//   req_wdata           : store data, right-aligned
//   rsp_valid           : one-cycle pulse per accepted request, in order
//   rsp_rdata           : load result, right-aligned and extended (0 otherwise)
//   rsp_err             : misaligned or illegal-size access
// ----------------------------------------------------------------------------
interface mem_bhw_ram_if #(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bhw_ram.sv
// ----------------------------------------------------------------------------
// mem_bhw_ram
// Byte-addressable data RAM with byte/half/word accesses, big-endian lane
// mapping, sign/zero-extended loads and misalignment detection. One request
// per cycle; each accepted request returns exactly one response RD_LAT
// (1 or 2) cycles after its accept edge.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mem_bhw_ram_if.slave request/response bundle
//
// Build option: define MEM_CLEAR_EN to zero the whole array after every
// reset (one word per cycle, req_ready held low until the sweep finishes).
// Without it the array keeps its contents across reset.
// ----------------------------------------------------------------------------
module mem_bhw_ram #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_bhw_ram_if.slave  bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_rd_word;
  logic             r_s1_valid;
  logic             r_s1_we;
  logic [1:0]       r_s1_size;
  logic             r_s1_unsigned;
  logic [1:0]       r_s1_off;
  logic             r_s1_err;

  logic             w_idle;
  logic             w_accept;
  logic             w_err;
  logic             w_wr_en;
  logic             w_clr_we;
  logic [IDX_W-1:0] w_clr_idx;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_fmt_data;
  logic             w_out_valid;
  logic             w_out_err;
  logic [31:0]      w_out_rdata;

  // --------------------------------------------------------------------------
  // Post-reset clear sweep
  // --------------------------------------------------------------------------
`ifdef MEM_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_clr_idx;

  // NOTE: clocked blocks use <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + IDX_W'(1);
      if (&r_clr_idx) r_state <= ST_IDLE;
    end
  end

  assign w_idle    = (r_state == ST_IDLE);
  assign w_clr_we  = ~rst & (r_state == ST_CLEAR);
  assign w_clr_idx = r_clr_idx;
`else
  assign w_idle    = 1'b1;
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = '0;
`endif

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign bus.req_ready = ~rst & w_idle;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_idx         = bus.req_addr[ADDR_W-1:2];
  assign w_off         = bus.req_addr[1:0];

  always_comb begin
    w_err = 1'b1;
    case (bus.req_size)
      SZ_BYTE: w_err = 1'b0;
      SZ_HALF: w_err = w_off[0];
      SZ_WORD: w_err = |w_off;
      default: w_err = 1'b1;
    endcase
  end

  // Lane 3 (bits 31:24) holds byte offset 0: big-endian.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    w_be     = 4'b0000;
    w_wlanes = '0;
    case (bus.req_size)
      SZ_BYTE: begin
        w_be     = 4'b1000 >> w_off;
        w_wlanes = {4{bus.req_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be     = w_off[1] ? 4'b0011 : 4'b1100;
        w_wlanes = {2{bus.req_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_be     = 4'b1111;
        w_wlanes = bus.req_wdata;
      end
      default: ;
    endcase
  end

  assign w_wr_en = w_accept & bus.req_we & ~w_err;

  // --------------------------------------------------------------------------
  // Storage: writes commit at the accept edge, reads are registered there
  // too, so a load accepted one cycle after a store already sees its data.
  // --------------------------------------------------------------------------
  // NOTE: the array and its read register are not reset; only control state is.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wlanes[8*l +: 8];
      end
    end
    if (w_accept) r_rd_word <= r_mem[w_idx];
  end

  // Stage-1 request attributes; only meaningful while r_s1_valid is high.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_we       <= bus.req_we;
      r_s1_size     <= bus.req_size;
      r_s1_unsigned <= bus.req_unsigned;
      r_s1_off      <= w_off;
      r_s1_err      <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else     r_s1_valid <= w_accept;
  end

  // --------------------------------------------------------------------------
  // Load formatting: select lanes, right-align, extend
  // --------------------------------------------------------------------------
  always_comb begin
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    case (r_s1_off)
      2'd0:    v_byte = r_rd_word[31:24];
      2'd1:    v_byte = r_rd_word[23:16];
      2'd2:    v_byte = r_rd_word[15:8];
      default: v_byte = r_rd_word[7:0];
    endcase
    v_half     = r_s1_off[1] ? r_rd_word[15:0] : r_rd_word[31:16];
    w_fmt_data = '0;
    if (!r_s1_we && !r_s1_err) begin
      case (r_s1_size)
        SZ_BYTE: w_fmt_data = r_s1_unsigned ? {24'h0, v_byte}
                                            : {{24{v_byte[7]}}, v_byte};
        SZ_HALF: w_fmt_data = r_s1_unsigned ? {16'h0, v_half}
                                            : {{16{v_half[15]}}, v_half};
        SZ_WORD: w_fmt_data = r_rd_word;
        default: w_fmt_data = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Response stage
  // --------------------------------------------------------------------------
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic        r_rsp_valid;
      logic        r_rsp_err;
      logic [31:0] r_rsp_rdata;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end else begin
          r_rsp_valid <= r_s1_valid;
          r_rsp_err   <= r_s1_valid & r_s1_err;
          r_rsp_rdata <= r_s1_valid ? w_fmt_data : '0;
        end
      end

      assign w_out_valid = r_rsp_valid;
      assign w_out_err   = r_rsp_err;
      assign w_out_rdata = r_rsp_rdata;
    end else begin : g_lat1
      assign w_out_valid = r_s1_valid;
      assign w_out_err   = r_s1_err;
      assign w_out_rdata = w_fmt_data;
    end
  endgenerate

  // Masking with ~rst drops in-flight responses the moment reset is raised.
  assign bus.rsp_valid = w_out_valid & ~rst;
  assign bus.rsp_err   = w_out_valid & ~rst & w_out_err;
  assign bus.rsp_rdata = (w_out_valid & ~rst) ? w_out_rdata : '0;

endmodule

// File: tb/tb_mem_bhw_ram.sv
// ----------------------------------------------------------------------------
// tb_mem_bhw_ram
// Drives the same request stream into two instances (RD_LAT=1 and RD_LAT=2)
// and checks every response against a byte-array memory model through a
// per-instance queue of expected responses, including response latency.
// ----------------------------------------------------------------------------
module tb_mem_bhw_ram;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << (ADDR_W - 2);

  localparam logic [1:0] B  = 2'b00;
  localparam logic [1:0] H  = 2'b01;
  localparam logic [1:0] W  = 2'b10;
  localparam logic [1:0] IL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        req_valid    = 1'b0;
  logic        req_we       = 1'b0;
  logic [1:0]  req_size     = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [7:0]  req_addr     = 8'h00;
  logic [31:0] req_wdata    = 32'h0;

  mem_bhw_ram_if #(.ADDR_W(ADDR_W)) bus1 ();
  mem_bhw_ram_if #(.ADDR_W(ADDR_W)) bus2 ();

  assign bus1.req_valid = req_valid;    assign bus2.req_valid = req_valid;
  assign bus1.req_we = req_we;          assign bus2.req_we = req_we;
  assign bus1.req_size = req_size;      assign bus2.req_size = req_size;
  assign bus1.req_unsigned = req_unsigned;
  assign bus2.req_unsigned = req_unsigned;
  assign bus1.req_addr = req_addr;      assign bus2.req_addr = req_addr;
  assign bus1.req_wdata = req_wdata;    assign bus2.req_wdata = req_wdata;

  mem_bhw_ram #(.ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_bhw_ram #(.ADDR_W(ADDR_W), .RD_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  logic [7:0] mdl [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Big-endian reference: byte address a holds the most significant byte.
  function automatic logic is_err(input logic [1:0] sz, input logic [7:0] a);
    return (sz == IL) || (sz == H && a[0]) || (sz == W && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [7:0] a, input logic [1:0] sz,
                                           input logic uns);
    logic [7:0] b0, b1;
    b0 = mdl[a];
    b1 = mdl[8'(a + 1)];
    case (sz)
      B:       return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
      H:       return uns ? {16'h0, b0, b1} : {{16{b0[7]}}, b0, b1};
      W:       return {b0, b1, mdl[8'(a + 2)], mdl[8'(a + 3)]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic mdl_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      B: mdl[a] = wd[7:0];
      H: begin
        mdl[a]           = wd[15:8];
        mdl[8'(a + 1)]   = wd[7:0];
      end
      W: begin
        mdl[a]           = wd[31:24];
        mdl[8'(a + 1)]   = wd[23:16];
        mdl[8'(a + 2)]   = wd[15:8];
        mdl[8'(a + 3)]   = wd[7:0];
      end
      default: ;
    endcase
  endtask

  // One request, accepted at the next edge; queues the expected response.
  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [7:0] a, input logic [31:0] wd);
    exp_t e;
    logic err;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    check("req_ready_dut1", {31'h0, bus1.req_ready}, 32'h1);
    check("req_ready_dut2", {31'h0, bus2.req_ready}, 32'h1);
    err   = is_err(sz, a);
    e.err = err;
    e.data = (we || err) ? 32'h0 : mdl_load(a, sz, uns);
    if (we && !err) mdl_store(a, sz, wd);
    @(posedge clk); #1;
    e.due = cyc;
    q1.push_back(e);
    e.due = cyc + 1;
    q2.push_back(e);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rsp_valid1"}, {31'h0, bus1.rsp_valid}, 32'h0);
    check({tag, "_rsp_rdata1"}, bus1.rsp_rdata, 32'h0);
    check({tag, "_rsp_err1"},   {31'h0, bus1.rsp_err}, 32'h0);
    check({tag, "_req_ready1"}, {31'h0, bus1.req_ready}, 32'h0);
    check({tag, "_rsp_valid2"}, {31'h0, bus2.rsp_valid}, 32'h0);
    check({tag, "_rsp_rdata2"}, bus2.rsp_rdata, 32'h0);
    check({tag, "_rsp_err2"},   {31'h0, bus2.rsp_err}, 32'h0);
    check({tag, "_req_ready2"}, {31'h0, bus2.req_ready}, 32'h0);
  endtask

  // Counts cycles until req_ready rises, bounded.
  task automatic wait_ready(input int exp_cycles);
    int n = 0;
    while (bus1.req_ready !== 1'b1 && n < 4 * DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_delay", n, exp_cycles);
    check("ready_dut2", {31'h0, bus2.req_ready}, 32'h1);
  endtask

  always @(negedge clk) begin
    if (bus1.rsp_valid === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_spurious_rsp", {31'h0, bus1.rsp_valid}, 32'h0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_rdata", bus1.rsp_rdata, e1.data);
        check("dut1_err", {31'h0, bus1.rsp_err}, {31'h0, e1.err});
        check("dut1_latency", cyc, e1.due);
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.rsp_valid === 1'b1) begin
      if (q2.size() == 0) begin
        check("dut2_spurious_rsp", {31'h0, bus2.rsp_valid}, 32'h0);
      end else begin
        e2 = q2.pop_front();
        check("dut2_rdata", bus2.rsp_rdata, e2.data);
        check("dut2_err", {31'h0, bus2.rsp_err}, {31'h0, e2.err});
        check("dut2_latency", cyc, e2.due);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_quiet("reset");
    rst = 1'b0;
    #1;
`ifdef MEM_CLEAR_EN
    wait_ready(DEPTH);
`else
    wait_ready(0);
`endif

    // Word store, then big-endian byte loads
    req(1'b1, W, 1'b0, 8'h10, 32'h1122_3344);
    for (int i = 0; i < 4; i++) req(1'b0, B, 1'b0, 8'(8'h10 + i), 32'h0);

    // Byte store into a zero word; upper wdata bits must be ignored
    req(1'b1, W, 1'b0, 8'h20, 32'h0);
    req(1'b1, B, 1'b0, 8'h21, 32'hFFFF_FFA5);
    req(1'b0, W, 1'b0, 8'h20, 32'h0);
    req(1'b0, B, 1'b0, 8'h21, 32'h0);
    req(1'b0, B, 1'b1, 8'h21, 32'h0);

    // Errors: misaligned half/word, illegal size; none may write
    req(1'b1, W, 1'b0, 8'h30, 32'hCAFE_BABE);
    req(1'b1, W, 1'b0, 8'h40, 32'h1357_9BDF);
    req(1'b0, H, 1'b0, 8'h31, 32'h0);
    req(1'b0, W, 1'b0, 8'h42, 32'h0);
    req(1'b1, W, 1'b0, 8'h42, 32'hFFFF_FFFF);
    req(1'b1, H, 1'b0, 8'h41, 32'hFFFF_FFFF);
    req(1'b0, IL, 1'b0, 8'h30, 32'h0);
    req(1'b1, IL, 1'b0, 8'h40, 32'h0);
    req(1'b0, W, 1'b0, 8'h30, 32'h0);
    req(1'b0, W, 1'b0, 8'h40, 32'h0);

    // Half accesses and sign extension
    req(1'b0, H, 1'b0, 8'h30, 32'h0);
    req(1'b0, H, 1'b1, 8'h32, 32'h0);
    req(1'b1, H, 1'b0, 8'h42, 32'hABCD_1234);
    req(1'b0, W, 1'b0, 8'h40, 32'h0);
    req(1'b0, B, 1'b0, 8'h31, 32'h0);
    req(1'b0, B, 1'b0, 8'h43, 32'h0);
    idle(2);

    // Back-to-back mixed traffic with read-after-write
    req(1'b1, W, 1'b0, 8'h84, 32'h0);
    req(1'b1, W, 1'b0, 8'h80, $urandom);
    req(1'b0, B, 1'b0, 8'h81, 32'h0);
    req(1'b0, H, 1'b1, 8'h82, 32'h0);
    req(1'b1, B, 1'b0, 8'h83, $urandom);
    req(1'b0, W, 1'b0, 8'h80, 32'h0);
    req(1'b1, H, 1'b0, 8'h86, $urandom);
    req(1'b0, H, 1'b0, 8'h86, 32'h0);
    req(1'b0, W, 1'b0, 8'h84, 32'h0);
    idle(3);

    // Reset with loads in flight: responses are dropped, requests ignored
    req(1'b0, W, 1'b0, 8'h10, 32'h0);
    req(1'b0, W, 1'b0, 8'h20, 32'h0);
    rst = 1'b1;
    q1.delete();
    q2.delete();
    #1;
    check_quiet("midrst");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = W;
    req_addr  = 8'h10;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_quiet("midrst_store");
    idle(1);
    rst = 1'b0;
`ifdef MEM_CLEAR_EN
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
`endif
    #1;
`ifdef MEM_CLEAR_EN
    wait_ready(DEPTH);
`else
    wait_ready(0);
`endif
    req(1'b0, W, 1'b0, 8'h10, 32'h0);
    req(1'b0, W, 1'b0, 8'h20, 32'h0);
    idle(3);

`ifdef MEM_CLEAR_EN
    // Reset during the sweep restarts it from index 0
    req(1'b1, W, 1'b0, 8'hFC, 32'h5555_AAAA);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    #1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("sweep_ready_mid", {31'h0, bus1.req_ready}, 32'h0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    #1;
    wait_ready(DEPTH);
    req(1'b0, W, 1'b0, 8'hFC, 32'h0);
    req(1'b0, W, 1'b0, 8'h44, 32'h0);
    idle(3);
`endif

    idle(2);
    check("dut1_drain", q1.size(), 32'h0);
    check("dut2_drain", q2.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
